psram_spi_sequencer: RTL and testbench

- Sequencer that owns the serial PSRAM (ESP-PSRAM64-class, SPI mode, SIO0/SIO1 only).
- After reset it waits out the device power-up time, then issues Reset Enable (0x66) and Reset (0x99).
- It then serves single-byte read (0x03) and write (0x02) requests from one requester through a valid/ready handshake.
- It drives the chip pins directly: sck = sys_clk/2, produced as a registered toggle with no clock gating. It sits between the memory-user logic and the top-level PSRAM pins.

---
 rtl/psram_spi_sequencer.sv | 164 ++++++++++++++++
 tb/tb_psram_spi_sequencer.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_spi_sequencer.sv
// Serial PSRAM sequencer: power-up wait, reset-enable/reset commands, then single-byte
// SPI read/write frames driven straight onto the chip pins with sck = sys_clk/2.
module psram_spi_sequencer #(
    parameter logic [15:0] PWRUP_CYCLES = 16'd22500,
    parameter logic [7:0]  GAP_CYCLES   = 8'd4,
    parameter int          ADDR_W       = 23
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              init_done,
    output logic              busy,
    output logic              ce_n,
    output logic              sck,
    output logic              si,
    input  logic              so
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_RSTEN,
        S_GAP1,
        S_RST,
        S_GAP2,
        S_IDLE,
        S_XFER,
        S_GAP3
    } state_t;

    state_t      state;
    logic [15:0] pwr_cnt;
    logic [7:0]  gap_cnt;
    logic [5:0]  bit_cnt;
    logic [39:0] shreg;
    logic [7:0]  rx;
    logic        active;
    logic        we_l;
    logic [23:0] addr24;
    logic [5:0]  last_bit;

    always_comb begin
        addr24 = '0;
        addr24[ADDR_W-1:0] = req_addr;
    end

    assign last_bit = (state == S_XFER) ? 6'd39 : 6'd7;

    // Frames are MSB-first out of shreg[39]; the first frame cycle only lowers ce_n,
    // after that sck toggles every cycle and si moves only on the falling half.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state     <= S_PWRUP;
            pwr_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx        <= '0;
            active    <= 1'b0;
            we_l      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            init_done <= 1'b0;
            busy      <= 1'b0;
            ce_n      <= 1'b1;
            sck       <= 1'b0;
            si        <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_PWRUP: begin
                    if (pwr_cnt >= PWRUP_CYCLES - 16'd1) begin
                        state <= S_RSTEN;
                        busy  <= 1'b1;
                        shreg <= {8'h66, 32'h0};
                    end else begin
                        pwr_cnt <= pwr_cnt + 16'd1;
                    end
                end

                S_RSTEN, S_RST, S_XFER: begin
                    if (!active) begin
                        active <= 1'b1;
                        ce_n   <= 1'b0;
                        sck    <= 1'b0;
                        si     <= shreg[39];
                        shreg  <= {shreg[38:0], 1'b0};
                    end else if (!sck) begin
                        sck <= 1'b1;
                        if (state == S_XFER && !we_l && bit_cnt >= 6'd32) begin
                            rx <= {rx[6:0], so};
                        end
                    end else begin
                        sck <= 1'b0;
                        if (bit_cnt == last_bit) begin
                            ce_n    <= 1'b1;
                            si      <= 1'b0;
                            active  <= 1'b0;
                            bit_cnt <= '0;
                            gap_cnt <= 8'd1;
                            if (state == S_RSTEN) begin
                                state <= S_GAP1;
                            end else if (state == S_RST) begin
                                state <= S_GAP2;
                            end else begin
                                state <= S_GAP3;
                                if (!we_l) begin
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= rx;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            si      <= shreg[39];
                            shreg   <= {shreg[38:0], 1'b0};
                        end
                    end
                end

                // The next frame spends one extra ce_n-high cycle on entry, so this gap ends one early.
                S_GAP1: begin
                    if (gap_cnt >= GAP_CYCLES - 8'd1) begin
                        state   <= S_RST;
                        gap_cnt <= '0;
                        shreg   <= {8'h99, 32'h0};
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                S_GAP2, S_GAP3: begin
                    if (gap_cnt >= GAP_CYCLES) begin
                        state     <= S_IDLE;
                        gap_cnt   <= '0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        we_l      <= req_we;
                        shreg     <= {(req_we ? 8'h02 : 8'h03), addr24, (req_we ? req_wdata : 8'h00)};
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_XFER;
                    end
                end

                default: state <= S_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_spi_sequencer.sv
// Directed bench for psram_spi_sequencer with a small SPI PSRAM bus model that decodes
// frames on sck rising edges and serves read data on so.
module tb_psram_spi_sequencer;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [22:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        init_done;
    logic        busy;
    logic        ce_n;
    logic        sck;
    logic        si;
    logic        so;

    int checks   = 0;
    int failures = 0;

    psram_spi_sequencer #(
        .PWRUP_CYCLES(16'd10),
        .GAP_CYCLES  (8'd2),
        .ADDR_W      (23)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .init_done(init_done),
        .busy     (busy),
        .ce_n     (ce_n),
        .sck      (sck),
        .si       (si),
        .so       (so)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          nbits;
        logic [39:0] data;
        int          low;
        int          start;
        int          stop;
        int          hb;
    } frame_t;

    frame_t      frames[$];
    int          ncyc = 0;
    int          cur_bits = 0;
    logic [39:0] cur_data = '0;
    logic [7:0]  cur_cmd = '0;
    int          cur_low = 0;
    int          cur_start = 0;
    int          cur_hb = 0;
    int          high_cnt = 0;
    int          si_viol = 0;
    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    logic [7:0]  rsp_last = '0;
    logic [7:0]  rd_byte = 8'h00;
    logic        prev_ce_n = 1'b1;
    logic        prev_sck = 1'b0;
    logic        prev_si = 1'b0;
    logic        early_ready = 1'b0;

    // PSRAM model: everything observed on the falling sys_clk edge, away from DUT updates.
    initial begin
        so = 1'b0;
        forever begin
            @(negedge sys_clk);
            ncyc++;
            if (!ce_n) begin
                if (prev_ce_n) begin
                    cur_bits  = 0;
                    cur_data  = '0;
                    cur_cmd   = '0;
                    cur_low   = 0;
                    cur_start = ncyc;
                    cur_hb    = high_cnt;
                end
                cur_low++;
                if (sck && !prev_sck) begin
                    cur_data = {cur_data[38:0], si};
                    cur_bits++;
                    if (cur_bits == 8) cur_cmd = cur_data[7:0];
                end
                if (sck && prev_sck && si !== prev_si) si_viol++;
                if (!sck && cur_bits >= 32 && cur_bits < 40 && cur_cmd == 8'h03)
                    so = rd_byte[3'(39 - cur_bits)];
                else
                    so = 1'b0;
                high_cnt = 0;
            end else begin
                if (!prev_ce_n)
                    frames.push_back('{cur_bits, cur_data, cur_low, cur_start, ncyc, cur_hb});
                high_cnt++;
                so = 1'b0;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_last = rsp_data;
                rsp_cyc  = ncyc;
            end
            if (req_ready && !init_done) early_ready = 1'b1;
            prev_ce_n = ce_n;
            prev_sck  = sck;
            prev_si   = si;
        end
    end

    task automatic step();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (frames.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Presents one request; hs is the cycle right after the handshake edge.
    task automatic do_request(input logic we, input logic [22:0] addr, input logic [7:0] wd,
                              output int hs, output bit ok);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        wait_ready(ok);
        hs = ncyc + 1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        sys_reset = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) step();
        checks++;
        if (ce_n !== 1'b1 || sck !== 1'b0 || si !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_pins ce_n=%b sck=%b si=%b expected 1 0 0", ce_n, sck, si);
        end
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_req ready=%b rsp_valid=%b rsp_data=%h expected 0 0 00",
                     req_ready, rsp_valid, rsp_data);
        end
        checks++;
        if (init_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_status init_done=%b busy=%b expected 0 0", init_done, busy);
        end
    endtask

    // Releases reset and follows the whole init sequence while a request is pending.
    task automatic test_init();
        int  high;
        bit  ok;
        int  done_cyc;
        frames.delete();
        early_ready = 1'b0;
        req_we    = 1'b1;
        req_addr  = 23'h000001;
        req_wdata = 8'hEE;
        req_valid = 1'b1;
        sys_reset = 1'b0;
        high = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!ce_n) break;
            high++;
            if (i == 3) begin
                checks++;
                if (busy !== 1'b0 || req_ready !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL pwrup_status busy=%b ready=%b expected 0 0", busy, req_ready);
                end
            end
        end
        checks++;
        if (high !== 10) begin
            failures++;
            $display("[TB] FAIL pwrup_len ce_n high %0d cycles expected 10", high);
        end
        ok = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (init_done) begin
                ok = 1'b1;
                done_cyc = ncyc;
                req_valid = 1'b0;
                break;
            end
        end
        checks++;
        if (!ok || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL init_done_seen done=%b ready=%b expected 1 1", ok, req_ready);
            req_valid = 1'b0;
            return;
        end
        checks++;
        if (frames.size() !== 2 || early_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL init_frames count=%0d early_ready=%b expected 2 0",
                     frames.size(), early_ready);
            return;
        end
        checks++;
        if (frames[0].nbits !== 8 || frames[0].data[7:0] !== 8'h66 || frames[0].low !== 16) begin
            failures++;
            $display("[TB] FAIL rsten_frame bits=%0d data=%h low=%0d expected 8 66 16",
                     frames[0].nbits, frames[0].data[7:0], frames[0].low);
        end
        checks++;
        if (frames[1].nbits !== 8 || frames[1].data[7:0] !== 8'h99 || frames[1].low !== 16) begin
            failures++;
            $display("[TB] FAIL rst_frame bits=%0d data=%h low=%0d expected 8 99 16",
                     frames[1].nbits, frames[1].data[7:0], frames[1].low);
        end
        checks++;
        if (frames[1].hb !== 2) begin
            failures++;
            $display("[TB] FAIL init_gap ce_n high %0d cycles expected 2", frames[1].hb);
        end
        checks++;
        if (done_cyc !== frames[1].stop + 2) begin
            failures++;
            $display("[TB] FAIL init_done_time cycle %0d expected %0d", done_cyc, frames[1].stop + 2);
        end
    endtask

    task automatic test_write();
        int hs;
        int rc;
        bit ok;
        frames.delete();
        rc = rsp_cnt;
        do_request(1'b1, 23'h123456, 8'hA5, hs, ok);
        checks++;
        if (!ok || req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_handshake accepted=%b ready_after=%b expected 1 0", ok, req_ready);
        end
        wait_frames(1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL wr_frame_timeout frames=%0d expected 1", frames.size());
            return;
        end
        checks++;
        if (frames[0].nbits !== 40 || frames[0].data !== 40'h02_123456_A5) begin
            failures++;
            $display("[TB] FAIL wr_frame bits=%0d data=%h expected 40 02123456a5",
                     frames[0].nbits, frames[0].data);
        end
        checks++;
        if (frames[0].low !== 80 || frames[0].start !== hs + 1) begin
            failures++;
            $display("[TB] FAIL wr_timing low=%0d start=%0d expected 80 %0d",
                     frames[0].low, frames[0].start, hs + 1);
        end
        wait_ready(ok);
        checks++;
        if (!ok || ncyc !== hs + 83) begin
            failures++;
            $display("[TB] FAIL wr_ready_return cycle %0d expected %0d", ncyc, hs + 83);
        end
        checks++;
        if (rsp_cnt !== rc) begin
            failures++;
            $display("[TB] FAIL wr_no_rsp rsp pulses %0d expected %0d", rsp_cnt, rc);
        end
    endtask

    task automatic test_read();
        int hs;
        int rc;
        bit ok;
        frames.delete();
        rd_byte = 8'h3C;
        rc = rsp_cnt;
        do_request(1'b0, 23'h123456, 8'h00, hs, ok);
        wait_frames(1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL rd_frame_timeout frames=%0d expected 1", frames.size());
            return;
        end
        checks++;
        if (frames[0].nbits !== 40 || frames[0].data !== 40'h03_123456_00) begin
            failures++;
            $display("[TB] FAIL rd_frame bits=%0d data=%h expected 40 0312345600",
                     frames[0].nbits, frames[0].data);
        end
        wait_ready(ok);
        checks++;
        if (rsp_cnt !== rc + 1 || rsp_last !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL rd_rsp pulses=%0d data=%h expected %0d 3c", rsp_cnt - rc, rsp_last, 1);
        end
        checks++;
        if (rsp_cyc !== hs + 81) begin
            failures++;
            $display("[TB] FAIL rd_rsp_time cycle %0d expected %0d", rsp_cyc, hs + 81);
        end
        checks++;
        if (rsp_data !== 8'h3C || rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_hold data=%h valid=%b expected 3c 0", rsp_data, rsp_valid);
        end
    endtask

    // req_valid stays high across four alternating requests at the top address.
    task automatic test_back_to_back();
        logic [39:0] exp_f [4];
        logic        we_seq [4];
        logic [7:0]  wd_seq [4];
        int          rc;
        bit          ok;
        frames.delete();
        rd_byte = 8'hC3;
        rc = rsp_cnt;
        we_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
        wd_seq = '{8'h11, 8'h00, 8'h22, 8'h00};
        exp_f  = '{40'h02_7FFFFF_11, 40'h03_7FFFFF_00, 40'h02_7FFFFF_22, 40'h03_7FFFFF_00};
        req_addr  = 23'h7FFFFF;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_we    = we_seq[i];
            req_wdata = wd_seq[i];
            wait_ready(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL b2b_accept_%0d ready never seen expected accept", i);
                req_valid = 1'b0;
                return;
            end
            step();
        end
        req_valid = 1'b0;
        wait_frames(4, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL b2b_frames count=%0d expected 4", frames.size());
            return;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (frames[i].data !== exp_f[i] || frames[i].nbits !== 40) begin
                failures++;
                $display("[TB] FAIL b2b_frame_%0d data=%h bits=%0d expected %h 40",
                         i, frames[i].data, frames[i].nbits, exp_f[i]);
            end
            if (i > 0) begin
                checks++;
                if (frames[i].hb < 2) begin
                    failures++;
                    $display("[TB] FAIL b2b_gap_%0d ce_n high %0d expected >=2", i, frames[i].hb);
                end
            end
        end
        wait_ready(ok);
        checks++;
        if (rsp_cnt !== rc + 2 || rsp_last !== 8'hC3) begin
            failures++;
            $display("[TB] FAIL b2b_rsp pulses=%0d data=%h expected 2 c3", rsp_cnt - rc, rsp_last);
        end
    endtask

    task automatic test_changed_inputs();
        int hs;
        bit ok;
        frames.delete();
        do_request(1'b1, 23'h0A0B0C, 8'h5A, hs, ok);
        req_we    = 1'b0;
        req_addr  = 23'h7FFFFF;
        req_wdata = 8'hFF;
        repeat (10) step();
        req_addr  = 23'h555555;
        req_wdata = 8'h0F;
        wait_frames(1, ok);
        checks++;
        if (!ok || frames[0].data !== 40'h02_0A0B0C_5A) begin
            failures++;
            $display("[TB] FAIL latched_fields data=%h expected 020a0b0c5a",
                     ok ? frames[0].data : 40'h0);
        end
        wait_ready(ok);
    endtask

    task automatic test_reset_mid_read();
        int  hs;
        int  rc;
        bit  ok;
        frames.delete();
        rd_byte = 8'h81;
        rc = rsp_cnt;
        req_we    = 1'b0;
        req_addr  = 23'h00ABCD;
        req_valid = 1'b1;
        wait_ready(ok);
        hs = ncyc + 1;
        step();
        req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!ce_n && cur_bits == 20) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL midrst_reach bit 20 not reached expected reached");
        end
        sys_reset = 1'b1;
        step();
        checks++;
        if (ce_n !== 1'b1 || sck !== 1'b0 || init_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_pins ce_n=%b sck=%b init_done=%b busy=%b expected 1 0 0 0",
                     ce_n, sck, init_done, busy);
        end
        repeat (2) step();
        frames.delete();
        sys_reset = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (init_done) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || frames.size() !== 2) begin
            failures++;
            $display("[TB] FAIL midrst_reinit done=%b frames=%0d expected 1 2", ok, frames.size());
        end else begin
            checks++;
            if (frames[0].data[7:0] !== 8'h66 || frames[1].data[7:0] !== 8'h99) begin
                failures++;
                $display("[TB] FAIL midrst_cmds got %h %h expected 66 99",
                         frames[0].data[7:0], frames[1].data[7:0]);
            end
        end
        checks++;
        if (rsp_cnt !== rc) begin
            failures++;
            $display("[TB] FAIL midrst_no_rsp pulses=%0d expected 0", rsp_cnt - rc);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write();
        test_read();
        test_back_to_back();
        test_changed_inputs();
        test_reset_mid_read();
        test_read();
        checks++;
        if (si_viol !== 0) begin
            failures++;
            $display("[TB] FAIL si_stable si changed %0d times while sck high expected 0", si_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
